// File: rtl/spi_config_master.sv
// SPI mode-0 configuration master.
// Sends one DW-bit word MSB first and captures the slave's previous
// contents from spi_miso. All outputs come straight from flops.
module spi_config_master #(
    parameter int DW      = 42,
    parameter int CLK_DIV = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [DW-1:0] cfg_data,
    output logic          busy,
    output logic          done,
    output logic [DW-1:0] rd_data,
    output logic          spi_clk,
    output logic          spi_csn,
    output logic          spi_mosi,
    input  logic          spi_miso
);

    localparam int            BW       = $clog2(DW + 1);
    localparam logic [7:0]    DIV_LAST = 8'(CLK_DIV - 1);
    localparam logic [BW-1:0] BITS     = BW'(DW);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LEAD,
        ST_HIGH,
        ST_LOW,
        ST_END,
        ST_GAP
    } state_t;

    state_t        state_reg;
    logic [7:0]    div_reg;
    logic [BW-1:0] bit_reg;
    logic [DW-1:0] tx_reg;
    logic [DW-1:0] rx_reg;

    wire div_last = (div_reg == DIV_LAST);

    // Transaction sequencer: every output is assigned on the same edge
    // that enters the state it belongs to, so no output is decoded.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_IDLE;
            div_reg   <= '0;
            bit_reg   <= '0;
            tx_reg    <= '0;
            rx_reg    <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            rd_data   <= '0;
            spi_clk   <= 1'b0;
            spi_csn   <= 1'b1;
            spi_mosi  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (start) begin
                        // Word is latched here; later cfg_data changes are ignored.
                        tx_reg    <= cfg_data;
                        spi_mosi  <= cfg_data[DW-1];
                        spi_csn   <= 1'b0;
                        busy      <= 1'b1;
                        div_reg   <= '0;
                        bit_reg   <= '0;
                        state_reg <= ST_LEAD;
                    end
                end
                ST_LEAD: begin
                    if (div_last) begin
                        // First rising edge: capture the slave MSB before it shifts.
                        div_reg   <= '0;
                        spi_clk   <= 1'b1;
                        rx_reg    <= {rx_reg[DW-2:0], spi_miso};
                        bit_reg   <= bit_reg + BW'(1);
                        state_reg <= ST_HIGH;
                    end else begin
                        div_reg <= div_reg + 8'd1;
                    end
                end
                ST_HIGH: begin
                    if (div_last) begin
                        // Falling edge: present the next bit for a full low phase.
                        div_reg   <= '0;
                        spi_clk   <= 1'b0;
                        spi_mosi  <= tx_reg[DW-2];
                        tx_reg    <= {tx_reg[DW-2:0], 1'b0};
                        state_reg <= ST_LOW;
                    end else begin
                        div_reg <= div_reg + 8'd1;
                    end
                end
                ST_LOW: begin
                    if (div_last) begin
                        div_reg <= '0;
                        if (bit_reg == BITS) begin
                            spi_csn   <= 1'b1;
                            spi_mosi  <= 1'b0;
                            busy      <= 1'b0;
                            done      <= 1'b1;
                            rd_data   <= rx_reg;
                            state_reg <= ST_END;
                        end else begin
                            spi_clk   <= 1'b1;
                            rx_reg    <= {rx_reg[DW-2:0], spi_miso};
                            bit_reg   <= bit_reg + BW'(1);
                            state_reg <= ST_HIGH;
                        end
                    end else begin
                        div_reg <= div_reg + 8'd1;
                    end
                end
                ST_END: begin
                    div_reg   <= '0;
                    state_reg <= ST_GAP;
                end
                ST_GAP: begin
                    // Guarantees csn-high spacing even with start held high.
                    if (div_last) begin
                        div_reg   <= '0;
                        bit_reg   <= '0;
                        state_reg <= ST_IDLE;
                    end else begin
                        div_reg <= div_reg + 8'd1;
                    end
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spi_config_master.sv
// Directed bench for spi_config_master: two instances (CLK_DIV=2 and 1),
// each looped back to a shift-register slave model.
module tb_spi_config_master;

    localparam int          DW   = 42;
    localparam logic [41:0] S0   = 42'h123_4567_89AB;
    localparam logic [41:0] S1   = 42'h3C0_FFEE_0011;
    localparam logic [41:0] A    = 42'h155_0F0F_3333;
    localparam logic [41:0] B    = 42'h2AA_AAAA_AAAA;
    localparam logic [41:0] C    = 42'h0F1_E2D3_C4B5;
    localparam logic [41:0] D    = 42'h3FF_0000_FFFF;
    localparam logic [41:0] E    = 42'h2C4_8D15_9E26;
    localparam logic [41:0] ONES = '1;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic [1:0]  start_s = 2'b00;
    logic [41:0] cfg0 = '0;
    logic [41:0] cfg1 = '0;
    wire  [1:0]  busy_w, done_w, sclk_w, csn_w, mosi_w, miso_w;
    wire  [41:0] rd0, rd1;

    logic [41:0] slv0 = S0;
    logic [41:0] slv1 = S1;

    int total = 0;
    int bad   = 0;

    // Per-transaction measurements filled in by run_txn.
    int          m_win, m_rises, m_dones, m_mosi_err, m_min_gap;
    logic [41:0] m_log, m_rd;

    always #5 clk = ~clk;

    spi_config_master #(.DW(DW), .CLK_DIV(2)) dut0 (
        .clk(clk), .rst_n(rst_n), .start(start_s[0]), .cfg_data(cfg0),
        .busy(busy_w[0]), .done(done_w[0]), .rd_data(rd0),
        .spi_clk(sclk_w[0]), .spi_csn(csn_w[0]), .spi_mosi(mosi_w[0]),
        .spi_miso(miso_w[0])
    );

    spi_config_master #(.DW(DW), .CLK_DIV(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start_s[1]), .cfg_data(cfg1),
        .busy(busy_w[1]), .done(done_w[1]), .rd_data(rd1),
        .spi_clk(sclk_w[1]), .spi_csn(csn_w[1]), .spi_mosi(mosi_w[1]),
        .spi_miso(miso_w[1])
    );

    // Slave models: shift on spi_clk rising edge, MSB drives miso.
    always @(posedge sclk_w[0]) slv0 <= {slv0[40:0], mosi_w[0]};
    always @(posedge sclk_w[1]) slv1 <= {slv1[40:0], mosi_w[1]};
    assign miso_w = {slv1[41], slv0[41]};

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end else begin
            $display("ok   %s = %0h", tag, got);
        end
    endtask

    task automatic set_cfg(input int i, input logic [41:0] v);
        if (i == 0) cfg0 = v;
        else        cfg1 = v;
    endtask

    // Start a transaction on instance i and measure it at negedges until
    // n_done done pulses are seen plus a quiet tail.
    task automatic run_txn(input int i, input logic [41:0] data, input int n_done,
                           input bit hold, input bit extra, input int cd, input string tag);
        int   cyc, quiet, low_run, gap_run, dones;
        bit   in_gap;
        logic cp, mp, sp, cs, sc, mo;
        @(negedge clk);
        set_cfg(i, data);
        start_s[i] = 1'b1;
        @(negedge clk);
        check({tag, "_busy_after_start"}, 64'(busy_w[i]), 64'd1);
        if (!hold) start_s[i] = 1'b0;
        m_win = 0; m_rises = 0; m_mosi_err = 0; m_min_gap = 1000; m_log = '0; m_rd = '0;
        cyc = 0; quiet = 0; low_run = 0; gap_run = 0; dones = 0; in_gap = 0;
        cp = 1'b0; mp = 1'b0; sp = 1'b1;
        while (cyc < 3000) begin
            if (cyc > 0) @(negedge clk);
            cs = csn_w[i]; sc = sclk_w[i]; mo = mosi_w[i];
            if (!cs) begin
                low_run++;
                if (in_gap) begin
                    if (gap_run < m_min_gap) m_min_gap = gap_run;
                    in_gap = 0;
                end
            end else begin
                if (!sp) begin
                    m_win = low_run; low_run = 0; in_gap = 1; gap_run = 0;
                end
                if (in_gap) gap_run++;
                if (mo) m_mosi_err++;
            end
            if (sc && !cp) begin
                m_rises++;
                m_log = {m_log[40:0], mo};
            end
            if ((mo !== mp) && !(cp && !sc) && (cs == sp)) m_mosi_err++;
            if (done_w[i]) begin
                dones++;
                if (dones == 1) m_rd = (i == 0) ? rd0 : rd1;
            end
            cp = sc; mp = mo; sp = cs;
            if (extra && cyc == 40) begin start_s[i] = 1'b1; set_cfg(i, ~data); end
            if (extra && cyc == 41) start_s[i] = 1'b0;
            if (dones >= n_done) begin
                if (hold) start_s[i] = 1'b0;
                quiet++;
                if (quiet > cd + 4) break;
            end
            cyc++;
        end
        m_dones = dones;
    endtask

    initial begin
        int rises, act;
        bit  ok;

        // Reset state.
        repeat (3) @(negedge clk);
        check("rst_csn",  64'(csn_w),  64'b11);
        check("rst_sclk", 64'(sclk_w), 64'b00);
        check("rst_mosi", 64'(mosi_w), 64'b00);
        check("rst_busy", 64'(busy_w), 64'b00);
        check("rst_done", 64'(done_w), 64'b00);
        check("rst_rd0",  64'(rd0),    64'd0);
        rst_n = 1'b1;

        // Loopback, first word, with an extra start pulse while busy.
        run_txn(0, A, 1, 1'b0, 1'b1, 2, "txA");
        check("txA_done_cnt", 64'(m_dones), 64'd1);
        check("txA_rd",       64'(m_rd),    64'(S0));
        check("txA_mosi",     64'(m_log),   64'(A));
        check("txA_win",      64'(m_win),   64'd170);
        check("txA_slave",    64'(slv0),    64'(A));

        // Alternating pattern; reads back the first word.
        run_txn(0, B, 1, 1'b0, 1'b0, 2, "txB");
        check("txB_win",      64'(m_win),      64'd170);
        check("txB_rises",    64'(m_rises),    64'd42);
        check("txB_mosi",     64'(m_log),      64'(B));
        check("txB_done_cnt", 64'(m_dones),    64'd1);
        check("txB_rd",       64'(m_rd),       64'(A));
        check("txB_mosi_err", 64'(m_mosi_err), 64'd0);
        check("txB_rd_hold",  64'(rd0),        64'(A));

        // Fastest divider, all ones.
        run_txn(1, ONES, 1, 1'b0, 1'b0, 1, "txF");
        check("txF_win",      64'(m_win),      64'd85);
        check("txF_rises",    64'(m_rises),    64'd42);
        check("txF_mosi",     64'(m_log),      64'(ONES));
        check("txF_rd",       64'(m_rd),       64'(S1));
        check("txF_mosi_err", 64'(m_mosi_err), 64'd0);

        // Reset in the middle of bit 20.
        @(negedge clk);
        cfg0 = D; start_s[0] = 1'b1;
        @(negedge clk);
        start_s[0] = 1'b0;
        rises = 0; ok = 1'b0;
        for (int c = 0; c < 500; c++) begin
            if (sclk_w[0] && rises == 0) begin end
            @(negedge clk);
            if (sclk_w[0] && (c == 0 || 1)) begin end
            if (rises < 20 && sclk_w[0] && !ok) begin rises++; ok = 1'b1; end
            if (!sclk_w[0]) ok = 1'b0;
            if (rises == 20) break;
        end
        check("rstmid_rises", 64'(rises), 64'd20);
        #1 rst_n = 1'b0;
        #1;
        check("rstmid_csn",  64'(csn_w[0]),  64'd1);
        check("rstmid_sclk", 64'(sclk_w[0]), 64'd0);
        check("rstmid_busy", 64'(busy_w[0]), 64'd0);
        act = 0;
        repeat (3) begin
            @(negedge clk);
            if (done_w[0]) act++;
        end
        check("rstmid_rd",   64'(rd0), 64'd0);
        rst_n = 1'b1;
        repeat (30) begin
            @(negedge clk);
            if (!csn_w[0] || sclk_w[0] || done_w[0] || mosi_w[0]) act++;
        end
        check("rstmid_quiet", 64'(act), 64'd0);

        // Full transaction after the interrupted one.
        run_txn(0, C, 1, 1'b0, 1'b0, 2, "txC");
        check("txC_rises",    64'(m_rises), 64'd42);
        check("txC_win",      64'(m_win),   64'd170);
        check("txC_mosi",     64'(m_log),   64'(C));
        check("txC_done_cnt", 64'(m_dones), 64'd1);
        check("txC_rd",       64'(m_rd),    64'({B[21:0], D[41:22]}));

        // start held high across three transactions.
        run_txn(0, E, 3, 1'b1, 1'b0, 2, "txH");
        check("txH_done_cnt", 64'(m_dones),            64'd3);
        check("txH_rises",    64'(m_rises),            64'd126);
        check("txH_gap_ok",   64'(m_min_gap >= 3),     64'd1);
        check("txH_win",      64'(m_win),              64'd170);
        check("txH_mosi_err", 64'(m_mosi_err),         64'd0);
        check("txH_idle",     64'({busy_w[0], csn_w[0]}), 64'b01);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/spi_config_master.md
SPI_CONFIG_MASTER -- requirements
Module: spi_config_master

Interface
REQ-001 Parameter DW, default 42: configuration word width in bits, equal to the configuration slave's shift-register length.
REQ-002 Parameter CLK_DIV, default 2: SPI half-period in clk cycles; legal range 1..255.
REQ-003 clk  input  1  system clock; all logic on the rising edge.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 start  input  1  transaction request, sampled only in IDLE.
REQ-006 cfg_data  input  DW  word to transmit, sent MSB first.
REQ-007 busy  output  1  high from the cycle after start is accepted until the transaction ends.
REQ-008 done  output  1  one-cycle pulse at transaction end.
REQ-009 rd_data  output  DW  word shifted back on spi_miso, which is the slave's previous contents.
REQ-010 spi_clk  output  1  SPI clock, mode 0, idle low.
REQ-011 spi_csn  output  1  chip select, active low.
REQ-012 spi_mosi  output  1  serial data to the slave.
REQ-013 spi_miso  input  1  serial data from the slave; its MSB is valid combinationally.

Function
REQ-014 spi_clk, spi_csn, spi_mosi, busy, done and rd_data shall each be driven directly from a register (no combinational output paths).
REQ-015 FSM states:
- IDLE: start=1 latches cfg_data into the TX shift register and moves to LEAD.
- LEAD: csn=0 and mosi=bit DW-1 from the next cycle; hold CLK_DIV cycles, then go to HIGH.
- HIGH: spi_clk=1 for CLK_DIV cycles, then go to LOW.
- LOW: spi_clk=0 for CLK_DIV cycles; mosi advances to the next bit on the falling-edge cycle; return to HIGH until DW high phases have completed, then go to END.
- END: csn=1, done=1, busy=0 for one cycle; go to GAP.
- GAP: csn high for CLK_DIV cycles with busy=0, start still ignored; go to IDLE.
REQ-016 Timing: csn is low for exactly (2*DW+1)*CLK_DIV cycles; spi_clk produces exactly DW rising edges.
REQ-017 Data setup: spi_mosi shall be stable for CLK_DIV cycles before each spi_clk rising edge and remain stable through the high phase.
REQ-018 MISO capture: on the clk edge that sets spi_clk 0->1, spi_miso shall be sampled into the RX shift register, LSB-in and MSB-first; this is the pre-shift slave MSB.
REQ-019 rd_data shall update only in the END cycle, with the complete RX word; it holds otherwise.
REQ-020 start is ignored when not in IDLE; cfg_data changes after acceptance have no effect.
REQ-021 A bit counter of width ceil(log2(DW+1)) and a divider counter of 8 bits are used; neither shall wrap mid-transaction.
REQ-022 start held high continuously starts a new transaction on every IDLE visit; consecutive csn-low windows shall be separated by at least CLK_DIV+1 cycles.
REQ-023 spi_mosi shall be 0 whenever csn=1.

Reset
REQ-024 While rst_n=0, from any state including mid-transaction, the outputs are: spi_csn=1, spi_clk=0, spi_mosi=0, busy=0, done=0, rd_data=0, FSM=IDLE, counters=0.
REQ-025 After rst_n deasserts, no SPI activity shall occur until start is seen in IDLE.

Verification
REQ-026 Loopback: slave model (DW shift register, reset contents S0). Send cfg=A, then cfg=B. Required: slave holds A after the first transaction; rd_data=S0 at the first done and A at the second done.
REQ-027 DW=42, CLK_DIV=2, cfg=42'h2AA_AAAA_AAAA. Required: csn low for 170 cycles, 42 spi_clk rising edges, mosi alternating 1,0,..., a single done pulse.
REQ-028 CLK_DIV=1, cfg all ones. Required: csn low for 85 cycles; every rising edge samples mosi=1.
REQ-029 rst_n pulsed low at bit 20. Required: csn=1 and spi_clk=0 asynchronously; no done pulse; a following start runs a full 42-bit transaction.
REQ-030 start held high for 3 transactions plus a start pulse while busy. Required: exactly 3 done pulses, gaps of at least CLK_DIV+1 cycles, and the extra pulse ignored.
